// File: rtl/branch_predict_unit_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch predictor.
// master = pipeline side, slave = predictor.
interface branch_predict_unit_if #(
    parameter int unsigned WORD  = 32,
    parameter int unsigned CNT_W = 32
);
    // Fetch lookup
    logic [WORD-1:0]  if_pc;
    logic             pred_taken;
    logic [WORD-1:0]  pred_target;

    // EX resolution
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_branch;
    logic [WORD-1:0]  ex_pc;
    logic [WORD-1:0]  ex_target;
    logic             ex_pred_taken;
    logic [WORD-1:0]  ex_pred_target;
    logic             ex_redirect;
    logic [WORD-1:0]  ex_redirect_pc;

    // Performance counters
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_branch, ex_pc, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, ex_redirect, ex_redirect_pc, br_cnt, miss_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_branch, ex_pc, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, ex_redirect, ex_redirect_pc, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch lookup is combinational; EX resolution produces a zero-latency redirect
// and updates the table at the clock edge.
module branch_predict_unit #(
    parameter int unsigned WORD       = 32,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned CNT_W      = 32,
    parameter bit          PREDICT_EN = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_unit_if.slave bus
);
    localparam int unsigned ENTRIES = 1 << IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Table storage
    logic            valid_q  [ENTRIES];
    tag_t            tag_q    [ENTRIES];
    logic [WORD-1:0] target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    idx_t if_idx;
    idx_t ex_idx;
    tag_t if_tag;
    tag_t ex_tag;

    logic            if_hit;
    logic            ex_hit;
    logic            lookup_taken;
    logic [WORD-1:0] lookup_target;
    logic            mispredict;
    logic [WORD-1:0] redirect_pc;
    logic            upd_branch;

    // Only the index/tag field of each PC feeds the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.if_pc, bus.ex_pc};

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign if_tag = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Fetch-side prediction; static not-taken when prediction is disabled
    always_comb begin
        if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        lookup_taken  = PREDICT_EN && if_hit && ctr_q[if_idx][1];
        lookup_target = lookup_taken ? target_q[if_idx] : bus.if_pc + WORD'(4);
    end

    // EX-side mispredict detection and correct next PC
    always_comb begin
        ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        mispredict = 1'b0;
        if (bus.ex_valid) begin
            if (bus.ex_is_branch) begin
                mispredict = (bus.ex_branch != bus.ex_pred_taken) ||
                             (bus.ex_branch && (bus.ex_pred_target != bus.ex_target));
            end else begin
                mispredict = bus.ex_pred_taken;
            end
        end
        redirect_pc = (bus.ex_is_branch && bus.ex_branch) ? bus.ex_target
                                                          : bus.ex_pc + WORD'(4);
        upd_branch  = bus.ex_valid && bus.ex_is_branch;
    end

    assign bus.pred_taken     = lookup_taken;
    assign bus.pred_target    = lookup_target;
    assign bus.ex_redirect    = mispredict;
    assign bus.ex_redirect_pc = redirect_pc;
    assign bus.br_cnt         = br_cnt_q;
    assign bus.miss_cnt       = miss_cnt_q;

    // Table training/allocation/invalidation; reset wins over any update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_branch) begin
            if (ex_hit) begin
                if (bus.ex_branch) begin
                    if (ctr_q[ex_idx] != 2'b11) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
                    end
                    target_q[ex_idx] <= bus.ex_target;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
                end
            end else if (bus.ex_branch) begin
                // Allocate weakly-taken, evicting whatever lived at this index.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= bus.ex_target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end else if (bus.ex_valid && ex_hit) begin
            // A non-branch matched an entry: the entry is an alias, drop it.
            valid_q[ex_idx] <= 1'b0;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (upd_branch && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (mispredict && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: three builds (default, prediction disabled,
// 4-bit counters) share one stimulus stream and one behavioural table model.
module tb_branch_predict_unit;
    localparam int unsigned N     = 64;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned TAG_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
    logic        ex_valid, ex_is_branch, ex_branch, ex_pred_taken;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_predict_unit_if #(.WORD(32), .CNT_W(32)) b0 ();
    branch_predict_unit_if #(.WORD(32), .CNT_W(32)) b1 ();
    branch_predict_unit_if #(.WORD(32), .CNT_W(4))  b2 ();

    branch_predict_unit #(.WORD(32), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(32), .PREDICT_EN(1'b1))
        d0 (.clk(clk), .rst(rst), .bus(b0.slave));
    branch_predict_unit #(.WORD(32), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(32), .PREDICT_EN(1'b0))
        d1 (.clk(clk), .rst(rst), .bus(b1.slave));
    branch_predict_unit #(.WORD(32), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(4), .PREDICT_EN(1'b1))
        d2 (.clk(clk), .rst(rst), .bus(b2.slave));

    assign b0.if_pc = if_pc;             assign b1.if_pc = if_pc;             assign b2.if_pc = if_pc;
    assign b0.ex_valid = ex_valid;       assign b1.ex_valid = ex_valid;       assign b2.ex_valid = ex_valid;
    assign b0.ex_is_branch = ex_is_branch;
    assign b1.ex_is_branch = ex_is_branch;
    assign b2.ex_is_branch = ex_is_branch;
    assign b0.ex_branch = ex_branch;     assign b1.ex_branch = ex_branch;     assign b2.ex_branch = ex_branch;
    assign b0.ex_pc = ex_pc;             assign b1.ex_pc = ex_pc;             assign b2.ex_pc = ex_pc;
    assign b0.ex_target = ex_target;     assign b1.ex_target = ex_target;     assign b2.ex_target = ex_target;
    assign b0.ex_pred_taken = ex_pred_taken;
    assign b1.ex_pred_taken = ex_pred_taken;
    assign b2.ex_pred_taken = ex_pred_taken;
    assign b0.ex_pred_target = ex_pred_target;
    assign b1.ex_pred_target = ex_pred_target;
    assign b2.ex_pred_target = ex_pred_target;

    // ---------------- behavioural model ----------------
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    longint      m_br, m_miss;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % N;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / (4 * N)) % (1 << TAG_W);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pt(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptg(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        if (!ex_valid) return 1'b0;
        if (ex_is_branch)
            return (ex_branch != ex_pred_taken) || (ex_branch && (ex_pred_target != ex_target));
        return ex_pred_taken;
    endfunction

    function automatic logic [31:0] m_rpc();
        return (ex_is_branch && ex_branch) ? ex_target : ex_pc + 32'd4;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic m_step();
        int unsigned i;
        i = idx_of(ex_pc);
        if (rst) begin
            m_reset();
        end else if (ex_valid) begin
            if (m_mis()) m_miss++;
            if (ex_is_branch) begin
                m_br++;
                if (m_hit(ex_pc)) begin
                    if (ex_branch) begin
                        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = ex_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (ex_branch) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(ex_pc);
                    m_tgt[i]   = ex_target;
                    m_ctr[i]   = 2;
                end
            end else if (m_hit(ex_pc)) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle on the falling edge, then advance the model for the next rising edge
    always @(negedge clk) begin
        chk("d0_pred_taken",  {63'd0, b0.pred_taken}, {63'd0, m_pt(if_pc)});
        chk("d0_pred_target", {32'd0, b0.pred_target}, {32'd0, m_ptg(if_pc)});
        chk("d0_redirect",    {63'd0, b0.ex_redirect}, {63'd0, m_mis()});
        chk("d0_redirect_pc", {32'd0, b0.ex_redirect_pc}, {32'd0, m_rpc()});
        chk("d0_br_cnt",      {32'd0, b0.br_cnt}, sat(m_br, 64'hFFFF_FFFF));
        chk("d0_miss_cnt",    {32'd0, b0.miss_cnt}, sat(m_miss, 64'hFFFF_FFFF));
        chk("d1_pred_taken",  {63'd0, b1.pred_taken}, 64'd0);
        chk("d1_pred_target", {32'd0, b1.pred_target}, {32'd0, if_pc + 32'd4});
        chk("d1_redirect",    {63'd0, b1.ex_redirect}, {63'd0, m_mis()});
        chk("d1_redirect_pc", {32'd0, b1.ex_redirect_pc}, {32'd0, m_rpc()});
        chk("d1_br_cnt",      {32'd0, b1.br_cnt}, sat(m_br, 64'hFFFF_FFFF));
        chk("d1_miss_cnt",    {32'd0, b1.miss_cnt}, sat(m_miss, 64'hFFFF_FFFF));
        chk("d2_pred_taken",  {63'd0, b2.pred_taken}, {63'd0, m_pt(if_pc)});
        chk("d2_pred_target", {32'd0, b2.pred_target}, {32'd0, m_ptg(if_pc)});
        chk("d2_br_cnt",      {60'd0, b2.br_cnt}, sat(m_br, 15));
        chk("d2_miss_cnt",    {60'd0, b2.miss_cnt}, sat(m_miss, 15));
        m_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic isb, input logic br,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptg);
        ex_valid       = v;
        ex_is_branch   = isb;
        ex_branch      = br;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    function automatic logic [31:0] pick_pc();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return 32'h1C00_0000 + ($urandom_range(0, 2) << (IDX_W + 2)) + ($urandom_range(0, 7) << 2);
    endfunction

    localparam logic [31:0] PC = 32'h1C00_0010;

    initial begin
        m_reset();
        rst   = 1'b1;
        if_pc = '0;
        set_ex(0, 0, 0, '0, '0, 0, '0);
        tick();
        tick();
        rst   = 1'b0;
        if_pc = PC;
        #1;
        chk("lit_rst_pred_taken",  {63'd0, b0.pred_taken}, 64'd0);
        chk("lit_rst_pred_target", {32'd0, b0.pred_target}, 64'h1C00_0014);
        chk("lit_rst_br_cnt",      {32'd0, b0.br_cnt}, 64'd0);

        // Cold miss: taken, predicted not-taken
        set_ex(1, 1, 1, PC, 32'h1C00_0100, 0, 32'h1C00_0014);
        #1;
        chk("lit_cold_redirect",    {63'd0, b0.ex_redirect}, 64'd1);
        chk("lit_cold_redirect_pc", {32'd0, b0.ex_redirect_pc}, 64'h1C00_0100);
        chk("lit_pen0_taken_redir", {63'd0, b1.ex_redirect}, 64'd1);
        tick();
        set_ex(0, 0, 0, '0, '0, 0, '0);
        #1;
        chk("lit_cold_pred_taken",  {63'd0, b0.pred_taken}, 64'd1);
        chk("lit_cold_pred_target", {32'd0, b0.pred_target}, 64'h1C00_0100);
        chk("lit_pen0_pred_taken",  {63'd0, b1.pred_taken}, 64'd0);
        chk("lit_cold_miss_cnt",    {32'd0, b0.miss_cnt}, 64'd1);

        // Target change on a predicted-taken hit
        tick();
        set_ex(1, 1, 1, PC, 32'h1C00_0200, 1, 32'h1C00_0100);
        #1;
        chk("lit_tchg_redirect",    {63'd0, b0.ex_redirect}, 64'd1);
        chk("lit_tchg_redirect_pc", {32'd0, b0.ex_redirect_pc}, 64'h1C00_0200);
        // ex_valid=0 with everything else asserted must be inert
        tick();
        set_ex(0, 1, 1, PC, 32'h1C00_0300, 1, 32'h1C00_0999);
        #1;
        chk("lit_tchg_pred_target", {32'd0, b0.pred_target}, 64'h1C00_0200);
        chk("lit_nv_redirect",      {63'd0, b0.ex_redirect}, 64'd0);
        tick();
        set_ex(0, 0, 0, '0, '0, 0, '0);
        #1;
        chk("lit_nv_pred_target", {32'd0, b0.pred_target}, 64'h1C00_0200);
        chk("lit_nv_br_cnt",      {32'd0, b0.br_cnt}, 64'd2);

        // Aliasing: non-branch hits a taken entry
        tick();
        set_ex(1, 0, 0, PC, PC, 1, 32'h1C00_0200);
        #1;
        chk("lit_alias_redirect",    {63'd0, b0.ex_redirect}, 64'd1);
        chk("lit_alias_redirect_pc", {32'd0, b0.ex_redirect_pc}, 64'h1C00_0014);
        tick();
        set_ex(0, 0, 0, '0, '0, 0, '0);
        #1;
        chk("lit_alias_pred_taken", {63'd0, b0.pred_taken}, 64'd0);

        // Re-allocate, then train down to strongly not-taken
        tick();
        set_ex(1, 1, 1, PC, 32'h1C00_0100, 0, 32'h1C00_0014);
        tick();
        set_ex(1, 1, 0, PC, 32'h1C00_0100, 1, 32'h1C00_0100);
        #1;
        chk("lit_sat1_pred_taken", {63'd0, b0.pred_taken}, 64'd1);
        chk("lit_sat1_redirect_pc", {32'd0, b0.ex_redirect_pc}, 64'h1C00_0014);
        tick();
        set_ex(1, 1, 0, PC, 32'h1C00_0100, 0, 32'h1C00_0014);
        #1;
        chk("lit_sat2_pred_taken",  {63'd0, b0.pred_taken}, 64'd0);
        chk("lit_pen0_nt_redirect", {63'd0, b1.ex_redirect}, 64'd0);
        tick();
        tick();
        // One taken from a saturated 00 must leave the prediction not-taken
        set_ex(1, 1, 1, PC, 32'h1C00_0100, 0, 32'h1C00_0014);
        tick();
        set_ex(0, 0, 0, '0, '0, 0, '0);
        #1;
        chk("lit_sat_floor_pred", {63'd0, b0.pred_taken}, 64'd0);
        chk("lit_sat_br_cnt",     {32'd0, b0.br_cnt}, 64'd7);
        chk("lit_sat_miss_cnt",   {32'd0, b0.miss_cnt}, 64'd6);

        // Push the 4-bit counter past its maximum
        for (int i = 0; i < 12; i++) begin
            tick();
            set_ex(1, 1, 0, 32'h1C00_0040, '0, 0, 32'h1C00_0044);
        end
        tick();
        set_ex(0, 0, 0, '0, '0, 0, '0);
        #1;
        chk("lit_cnt4_sat",   {60'd0, b2.br_cnt}, 64'd15);
        chk("lit_cnt32_more", {32'd0, b0.br_cnt}, 64'd19);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst          = ($urandom_range(0, 199) == 0);
            if_pc        = pick_pc();
            ex_pc        = pick_pc();
            ex_target    = pick_pc();
            ex_valid     = ($urandom_range(0, 9) < 8);
            ex_is_branch = ($urandom_range(0, 9) < 7);
            ex_branch    = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 7) begin
                ex_pred_taken  = m_pt(ex_pc);
                ex_pred_target = m_ptg(ex_pc);
            end else begin
                ex_pred_taken  = $urandom_range(0, 1);
                ex_pred_target = pick_pc();
            end
        end
        tick();
        rst = 1'b0;
        set_ex(0, 0, 0, '0, '0, 0, '0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter WORD, default 32: PC/target width.
REQ-002 SHALL have parameter IDX_W, default 6: table index width; 2^IDX_W entries.
REQ-003 SHALL have parameter TAG_W, default 8: stored PC tag width.
REQ-004 SHALL have parameter CNT_W, default 32: performance counter width.
REQ-005 SHALL have parameter PREDICT_EN, default 1: 0 = static not-taken mode.
REQ-006 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-007 SHALL have rst  in  1  synchronous active-high reset.
REQ-008 SHALL have if_pc  in  WORD  fetch PC to predict.
REQ-009 SHALL have pred_taken  out  1  prediction for if_pc, combinational.
REQ-010 SHALL have pred_target  out  WORD  predicted next PC for if_pc, combinational.
REQ-011 SHALL have ex_valid  in  1  EX instruction valid, not flushed.
REQ-012 SHALL have ex_is_branch  in  1  EX instruction is a conditional/unconditional branch.
REQ-013 SHALL have ex_branch  in  1  actual branch outcome, taken = 1.
REQ-014 SHALL have ex_pc  in  WORD  PC of EX instruction.
REQ-015 SHALL have ex_target  in  WORD  resolved branch target.
REQ-016 SHALL have ex_pred_taken  in  1  pred_taken carried down the pipeline with this instruction.
REQ-017 SHALL have ex_pred_target  in  WORD  pred_target carried down the pipeline with this instruction.
REQ-018 SHALL have ex_redirect  out  1  mispredict; flush younger instructions and refetch.
REQ-019 SHALL have ex_redirect_pc  out  WORD  correct next PC.
REQ-020 SHALL have br_cnt  out  CNT_W  resolved branch count.
REQ-021 SHALL have miss_cnt  out  CNT_W  mispredict count.

Function
REQ-022 SHALL hold 2^IDX_W register entries: valid, tag[TAG_W], target[WORD], ctr[2].
REQ-023 SHALL index by pc[IDX_W+1:2] and take the tag from pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-024 SHALL drive pred_taken = hit & ctr[1], where hit = valid & tag match.
REQ-025 SHALL drive pred_target = entry target when pred_taken, else if_pc+4, mod 2^WORD.
REQ-026 SHALL force pred_taken=0 and pred_target=if_pc+4 when PREDICT_EN=0.
REQ-027 SHALL compute mispredict only when ex_valid=1:
- branch: ex_branch != ex_pred_taken, or (ex_branch & ex_pred_target != ex_target);
- non-branch: ex_pred_taken=1.
REQ-028 SHALL drive ex_redirect = mispredict combinationally, with zero latency in EX.
REQ-029 SHALL drive ex_redirect_pc = ex_target when ex_is_branch & ex_branch, else ex_pc+4.
REQ-030 SHALL update the table at the clock edge when ex_valid & ex_is_branch, using ex_pc index/tag:
- hit: ctr saturating +1 if taken, -1 if not, bounded 00..11; target <= ex_target if taken;
- miss & taken: allocate valid=1, tag, target=ex_target, ctr=10, overwriting any entry;
- miss & not taken: no change.
REQ-031 SHALL clear valid at the clock edge when ex_valid & !ex_is_branch & hit at ex_pc (aliasing cleanup).
REQ-032 SHALL leave same-cycle lookup and update to the same index seeing the old entry; the new value is visible the next cycle.
REQ-033 SHALL ignore all EX inputs when ex_valid=0: no redirect, update or count.
REQ-034 SHALL increment br_cnt on each ex_valid & ex_is_branch, and miss_cnt on each mispredict, both saturating at all-ones.
REQ-035 SHALL keep table updates and counters active when PREDICT_EN=0; only the outputs are forced.

Reset
REQ-036 SHALL on rst clear all valid bits, set every ctr=01, and zero br_cnt and miss_cnt.
REQ-037 SHALL output pred_taken=0 and pred_target=if_pc+4 while in and after reset, until the first allocation.
REQ-038 SHALL give rst priority over a same-cycle update: no entry written, no count.
REQ-039 SHALL not gate combinational ex_redirect during rst; the pipeline discards it.

Verification
REQ-040 SHALL cover cold miss: rst, then branch at ex_pc=0x1C000010 taken to 0x1C000100 with ex_pred_taken=0 -> ex_redirect=1, pc 0x1C000100; next cycle if_pc=0x1C000010 gives pred_taken=1, target 0x1C000100.
REQ-041 SHALL cover saturation: same branch resolved not-taken 3 times -> ctr 10->01->00->00; pred_taken=0 after the first; miss_cnt counts only real mispredicts.
REQ-042 SHALL cover target change: hit predicted 0x1C000100, actual taken to 0x1C000200 -> redirect to 0x1C000200, entry target updated.
REQ-043 SHALL cover aliasing: non-branch at an index/tag with a taken entry, ex_pred_taken=1, ex_pc=0x1C000010 -> redirect to 0x1C000014, entry invalidated.
REQ-044 SHALL cover PREDICT_EN=0: taken branch -> redirect to target; not-taken branch -> no redirect; pred_taken is always 0.
REQ-045 SHALL cover edge cases: ex_valid=0 with every other input active -> no state change; br_cnt preloaded near max via a CNT_W=4 build -> holds at 15.
